// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: scans the PMP entries one per cycle against the first and last
// byte of an AXI burst and returns a single allow/deny verdict with the deciding entry index.

module pmp_entry #(
   parameter int unsigned PLEN           = 56,
   parameter int unsigned PMP_LEN        = 54,
   parameter int unsigned PMPGranularity = 2
) (
   input  logic [PLEN-1:0]    addr_i,
   input  logic [PMP_LEN-1:0] conf_addr_i,
   input  logic [PMP_LEN-1:0] conf_addr_prev_i,
   input  logic [1:0]         conf_addr_mode_i,
   output logic               match_o
);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_TOR   = 2'd1;
   localparam logic [1:0] MODE_NA4   = 2'd2;
   localparam logic [1:0] MODE_NAPOT = 2'd3;

   logic [PLEN-1:0]    base_s;
   logic [PLEN-1:0]    prev_base_s;
   logic [PLEN-1:0]    mask_s;
   logic [PMP_LEN-1:0] napot_addr_s;
   logic [7:0]         ones_s;
   logic [7:0]         size_s;
   logic               ones_done_s;

   // Region decode: TOR bounds, or a power-of-two window sized by the trailing ones of pmpaddr
   always_comb begin
      base_s       = {conf_addr_i, 2'b00};
      prev_base_s  = {conf_addr_prev_i, 2'b00};
      napot_addr_s = conf_addr_i;
      for (int i = 0; i < int'(PMPGranularity) - 1; i++) begin
         napot_addr_s[i] = 1'b1;
      end
      ones_s      = 8'd0;
      ones_done_s = 1'b0;
      for (int i = 0; i < int'(PMP_LEN); i++) begin
         if (!ones_done_s && napot_addr_s[i]) begin
            ones_s = ones_s + 8'd1;
         end else begin
            ones_done_s = 1'b1;
         end
      end
      if (conf_addr_mode_i == MODE_NA4) begin
         size_s = 8'd2;
      end else begin
         size_s = ones_s + 8'd3;
      end
      mask_s = {PLEN{1'b1}} << size_s;
      case (conf_addr_mode_i)
         MODE_OFF:   match_o = 1'b0;
         MODE_TOR:   match_o = (addr_i >= prev_base_s) && (addr_i < base_s);
         MODE_NA4,
         MODE_NAPOT: match_o = ((addr_i & mask_s) == (base_s & mask_s));
         default:    match_o = 1'b0;
      endcase
   end

endmodule

module pmp_seq_checker #(
   parameter int unsigned PLEN           = 56,
   parameter int unsigned PMP_LEN        = 54,
   parameter int unsigned NR_ENTRIES     = 16,
   parameter int unsigned PMPGranularity = 2,
   localparam int unsigned IW            = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                req_valid_i,
   output logic                                req_ready_o,
   input  logic [PLEN-1:0]                     req_addr_i,
   input  logic [7:0]                          req_len_i,
   input  logic [2:0]                          req_size_i,
   input  logic                                req_write_i,
   input  logic                                req_mmode_i,
   input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr_i,
   input  logic [NR_ENTRIES-1:0][7:0]          conf_i,
   output logic                                resp_valid_o,
   input  logic                                resp_ready_i,
   output logic                                resp_allow_o,
   output logic                                resp_hit_o,
   output logic [IW-1:0]                       resp_idx_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NR_ENTRIES - 1);

   state_t          state_r;
   logic [PLEN-1:0] addr_r;
   logic [PLEN-1:0] end_r;
   logic            write_r;
   logic            mmode_r;
   logic [IW-1:0]   scan_idx_r;
   logic            req_ready_r;
   logic            resp_valid_r;
   logic            resp_allow_r;
   logic            resp_hit_r;
   logic [IW-1:0]   resp_idx_r;

   logic [PLEN:0]        beats_s;
   logic [PLEN:0]        end_s;
   logic [PMP_LEN-1:0]   cur_addr_s;
   logic [PMP_LEN-1:0]   prev_addr_s;
   logic [7:0]           cur_cfg_s;
   logic                 start_match_s;
   logic                 end_match_s;
   logic                 perm_s;
   logic                 unused_cfg_s;

   // Last byte of the burst; the extra top bit flags a wrap past the address space
   always_comb begin
      beats_s = {{(PLEN - 7){1'b0}}, req_len_i} + {{PLEN{1'b0}}, 1'b1};
      end_s   = {1'b0, req_addr_i} + (beats_s << req_size_i) - {{PLEN{1'b0}}, 1'b1};
   end

   // Select the entry under scan and its TOR lower bound
   always_comb begin
      cur_addr_s = conf_addr_i[scan_idx_r];
      cur_cfg_s  = conf_i[scan_idx_r];
      if (scan_idx_r == {IW{1'b0}}) begin
         prev_addr_s = {PMP_LEN{1'b0}};
      end else begin
         prev_addr_s = conf_addr_i[scan_idx_r - {{(IW - 1){1'b0}}, 1'b1}];
      end
      // An unlocked entry never restricts M-mode
      if (!cur_cfg_s[7] && mmode_r) begin
         perm_s = 1'b1;
      end else begin
         perm_s = write_r ? cur_cfg_s[1] : cur_cfg_s[0];
      end
   end

   // Fold cfg bits that have no meaning here
   always_comb begin
      unused_cfg_s = 1'b0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
         unused_cfg_s = unused_cfg_s ^ conf_i[i][6] ^ conf_i[i][5] ^ conf_i[i][2];
      end
   end

   pmp_entry #(
      .PLEN           (PLEN),
      .PMP_LEN        (PMP_LEN),
      .PMPGranularity (PMPGranularity)
   ) u_start_entry (
      .addr_i           (addr_r),
      .conf_addr_i      (cur_addr_s),
      .conf_addr_prev_i (prev_addr_s),
      .conf_addr_mode_i (cur_cfg_s[4:3]),
      .match_o          (start_match_s)
   );

   pmp_entry #(
      .PLEN           (PLEN),
      .PMP_LEN        (PMP_LEN),
      .PMPGranularity (PMPGranularity)
   ) u_end_entry (
      .addr_i           (end_r),
      .conf_addr_i      (cur_addr_s),
      .conf_addr_prev_i (prev_addr_s),
      .conf_addr_mode_i (cur_cfg_s[4:3]),
      .match_o          (end_match_s)
   );

   // Control FSM with registered handshake and verdict outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= IDLE;
         addr_r       <= {PLEN{1'b0}};
         end_r        <= {PLEN{1'b0}};
         write_r      <= 1'b0;
         mmode_r      <= 1'b0;
         scan_idx_r   <= {IW{1'b0}};
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_allow_r <= 1'b0;
         resp_hit_r   <= 1'b0;
         resp_idx_r   <= {IW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid_i && req_ready_r) begin
                  addr_r      <= req_addr_i;
                  end_r       <= end_s[PLEN-1:0];
                  write_r     <= req_write_i;
                  mmode_r     <= req_mmode_i;
                  scan_idx_r  <= {IW{1'b0}};
                  req_ready_r <= 1'b0;
                  if (end_s[PLEN]) begin
                     state_r      <= RESP;
                     resp_valid_r <= 1'b1;
                     resp_allow_r <= 1'b0;
                     resp_hit_r   <= 1'b0;
                     resp_idx_r   <= {IW{1'b0}};
                  end else begin
                     state_r <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (start_match_s && end_match_s) begin
                  state_r      <= RESP;
                  resp_valid_r <= 1'b1;
                  resp_allow_r <= perm_s;
                  resp_hit_r   <= 1'b1;
                  resp_idx_r   <= scan_idx_r;
               end else if (start_match_s || end_match_s) begin
                  state_r      <= RESP;
                  resp_valid_r <= 1'b1;
                  resp_allow_r <= 1'b0;
                  resp_hit_r   <= 1'b1;
                  resp_idx_r   <= scan_idx_r;
               end else if (scan_idx_r == LAST_IDX) begin
                  state_r      <= RESP;
                  resp_valid_r <= 1'b1;
                  resp_allow_r <= mmode_r;
                  resp_hit_r   <= 1'b0;
                  resp_idx_r   <= {IW{1'b0}};
               end else begin
                  scan_idx_r <= scan_idx_r + {{(IW - 1){1'b0}}, 1'b1};
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  state_r      <= IDLE;
                  req_ready_r  <= 1'b1;
                  resp_valid_r <= 1'b0;
                  resp_allow_r <= 1'b0;
                  resp_hit_r   <= 1'b0;
                  resp_idx_r   <= {IW{1'b0}};
               end
            end
            default: begin
               state_r      <= IDLE;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
               resp_allow_r <= 1'b0;
               resp_hit_r   <= 1'b0;
               resp_idx_r   <= {IW{1'b0}};
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_r;
   assign resp_valid_o = resp_valid_r;
   assign resp_allow_o = resp_allow_r;
   assign resp_hit_o   = resp_hit_r;
   assign resp_idx_o   = resp_idx_r;

endmodule
